booth_multiplier: RTL and testbench

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/booth_multiplier_pkg.sv | 31 +++
 rtl/booth_multiplier_if.sv | 31 +++
 rtl/booth_multiplier_step.sv | 36 +++
 rtl/booth_multiplier.sv | 127 ++++++++++++
 tb/tb_booth_multiplier.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   WIDTH_DEFAULT : default operand width (product is twice as wide)
//   state_e       : controller states IDLE / RUN / DONE
//   booth_op_e    : Booth recode result NOP / ADD / SUB
//   booth_recode  : maps {Q[0], q_m1} to the partial-product action
package booth_multiplier_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  // 01 -> end of a run of ones: add M; 10 -> start of a run: subtract M.
  function automatic booth_op_e booth_recode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Handshake/data bundle between a requester and booth_multiplier.
//   master : drives start, multiplicand, multiplier; observes busy, done, product
//   slave  : the multiplier side (directions reversed)
// With MULT_OVERFLOW_FLAG_EN defined an extra 1-bit overflow signal is carried.
interface booth_multiplier_if
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
`ifdef MULT_OVERFLOW_FLAG_EN
  logic                 overflow;

  modport master (output start, multiplicand, multiplier,
                  input  busy, done, product, overflow);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, done, product, overflow);
`else
  modport master (output start, multiplicand, multiplier,
                  input  busy, done, product);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, done, product);
`endif

endinterface

// File: rtl/booth_multiplier_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   a_i/q_i/q_m1_i : current accumulator, multiplier shift register, guard bit
//   m_i            : multiplicand sign-extended to WIDTH+1 bits
//   a_o/q_o/q_m1_o : values after add/sub and arithmetic right shift
module booth_step
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_m1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_m1_o
);

  booth_op_e      op;
  logic [WIDTH:0] sum;

  always_comb begin
    op = booth_recode(q_i[0], q_m1_i);
    sum = a_i;
    case (op)
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
    // Arithmetic shift of {A,Q,q_m1}: A's sign bit is replicated.
    a_o    = {sum[WIDTH], sum[WIDTH:1]};
    q_o    = {sum[0], q_i[WIDTH-1:1]};
    q_m1_o = q_i[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed radix-2 Booth multiplier, one bit per cycle.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : booth_multiplier_if.slave (start/operands in; busy/done/product out)
// A multiply accepted at edge k is busy for WIDTH cycles, then done pulses for
// one cycle with the new product. Start is honoured in IDLE and DONE only.
// Optional: MULT_OVERFLOW_FLAG_EN adds bus.overflow, set when the product does
// not fit in a signed WIDTH-bit value.
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  booth_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_m1_q, q_m1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               load;

  logic [WIDTH:0]     a_s;
  logic [WIDTH-1:0]   q_s;
  logic               q_m1_s;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (a_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .a_o    (a_s),
    .q_o    (q_s),
    .q_m1_o (q_m1_s)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q_m1_d    = q_m1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    load      = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load = bus.start;
      end
      ST_RUN: begin
        bus.busy = 1'b1;
        a_d      = a_s;
        q_d      = q_s;
        q_m1_d   = q_m1_s;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          // Final step: result is taken straight from the step outputs.
          product_d = {a_s[WIDTH-1:0], q_s};
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        load     = bus.start;
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_RUN;
      a_d     = '0;
      q_d     = bus.multiplier;
      q_m1_d  = 1'b0;
      m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q_m1_q    <= q_m1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;

`ifdef MULT_OVERFLOW_FLAG_EN
  // Fits in WIDTH signed bits iff the top WIDTH+1 product bits are all equal.
  logic [WIDTH:0] prod_top_d;
  logic           overflow_q;

  assign prod_top_d = product_d[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= ~((&prod_top_d) | ~(|prod_top_d));
  end

  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;
  import booth_multiplier_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  booth_multiplier_if #(.WIDTH(W)) bus ();

  booth_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] last_exp = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: exact signed product by plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint ea, eb, p;
    ea = longint'($signed(a));
    eb = longint'($signed(b));
    p  = ea * eb;
    return p[2*W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p, lim;
    p   = longint'($signed(a)) * longint'($signed(b));
    lim = longint'(1) << (W - 1);
    return (p > lim - 1) || (p < -lim);
  endfunction

  // Present start with operands; returns at sample point of cycle 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Called at cycle-1 sample point; returns at the sample point where done is seen.
  task automatic wait_done(output int cyc, output int nbusy, output int nhold_bad);
    cyc = 1; nbusy = 0; nhold_bad = 0;
    while (bus.done !== 1'b1 && cyc <= 200) begin
      if (bus.busy === 1'b1) nbusy++;
      if (bus.product !== last_exp) nhold_bad++;
      tick();
      cyc++;
    end
  endtask

  // Full multiply from issue to done; leaves us at the done sample point.
  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, nbusy, nhold;
    logic [2*W-1:0] exp;
    exp = ref_prod(a, b);
    issue(a, b);
    wait_done(cyc, nbusy, nhold);
    check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(W));
    check({tag, "_hold"}, 64'(nhold), 64'd0);
    check({tag, "_product"}, 64'(bus.product), 64'(exp));
`ifdef MULT_OVERFLOW_FLAG_EN
    check({tag, "_overflow"}, 64'(bus.overflow), 64'(ref_ovf(a, b)));
`endif
    $display("mul %s: a=%0d b=%0d product=0x%08h latency=%0d", tag,
             $signed(a), $signed(b), bus.product, cyc);
    last_exp = exp;
  endtask

  // Step past the done cycle with start low: done must be a single pulse.
  task automatic after_done(input string tag);
    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_idle_product"}, 64'(bus.product), 64'(last_exp));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int cyc, nbusy, nhold, ndone;
    logic [W-1:0] a, b;

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // Reset state
    tick(); tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
`ifdef MULT_OVERFLOW_FLAG_EN
    check("rst_overflow", 64'(bus.overflow), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Directed values
    mul("3x5", 16'd3, 16'd5);
    check("3x5_const", 64'(bus.product), 64'h0000_000F);
    after_done("3x5");
    mul("m7x6", -16'sd7, 16'd6);
    check("m7x6_const", 64'(bus.product), 64'hFFFF_FFD6);
    after_done("m7x6");
    mul("min_sq", 16'h8000, 16'h8000);
    check("min_sq_const", 64'(bus.product), 64'h4000_0000);
    after_done("min_sq");
    mul("0xm1", 16'd0, 16'hFFFF);
    check("0xm1_const", 64'(bus.product), 64'h0);
    after_done("0xm1");
    mul("300sq", 16'd300, 16'd300);
    check("300sq_const", 64'(bus.product), 64'h0001_5F90);
    after_done("300sq");
    mul("100xm100", 16'd100, -16'sd100);
    check("100xm100_const", 64'(bus.product), 64'hFFFF_D8F0);
    after_done("100xm100");

    // Start during RUN is ignored
    issue(16'd3, 16'd5);
    cyc = 1; nbusy = 0; nhold = 0;
    while (bus.done !== 1'b1 && cyc <= 200) begin
      if (bus.busy === 1'b1) nbusy++;
      if (cyc == 5) begin
        bus.start = 1'b1; bus.multiplicand = 16'd9; bus.multiplier = 16'd9;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check("ignore_latency", 64'(cyc), 64'(W + 1));
    check("ignore_busy_cycles", 64'(nbusy), 64'(W));
    check("ignore_product", 64'(bus.product), 64'd15);
    last_exp = 32'd15;
    $display("mul ignore-start: product=0x%08h latency=%0d", bus.product, cyc);
    after_done("ignore");

    // Reset mid-run
    issue(16'd7, 16'd7);
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_product", 64'(bus.product), 64'd0);
    tick();
    rst = 1'b0;
    last_exp = '0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    $display("reset mid-run: done pulses after reset=%0d", ndone);
    mul("2xm2", 16'd2, -16'sd2);
    check("2xm2_const", 64'(bus.product), 64'hFFFF_FFFC);
    after_done("2xm2");

    // Back-to-back: 4x4 then 5x5 started in the DONE cycle
    mul("b2b_4x4", 16'd4, 16'd4);
    check("b2b_first", 64'(bus.product), 64'd16);
    mul("b2b_5x5", 16'd5, 16'd5);
    check("b2b_second", 64'(bus.product), 64'd25);
    after_done("b2b");

    // Randomized, with random back-to-back chaining
    for (int i = 0; i < 40; i++) begin
      a = pick_operand();
      b = pick_operand();
      mul($sformatf("rnd%0d", i), a, b);
      if ($urandom_range(0, 1) == 0) begin
        after_done($sformatf("rnd%0d", i));
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
    end
    after_done("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
